// File: rtl/stream_xor_checksum_pkg.sv
// Shared types for the streaming XOR checksum unit.
package stream_xor_checksum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/mux_xor_bit.sv
// One-bit XOR built only from 2:1 multiplexers and the constants 0/1.
module mux_xor_bit (
   input  logic a,
   input  logic b,
   output logic y_c
);

   logic b_n;

   // Inverter as a mux: selecting between constants on b.
   always_comb b_n = b ? 1'b0 : 1'b1;

   always_comb y_c = a ? b_n : b;

endmodule

// File: rtl/stream_xor_checksum.sv
// Streaming XOR checksum: folds packet beats through mux-built XOR cells,
// counts beats with saturation, and holds the result in a one-entry register.
module stream_xor_checksum
   import stream_xor_checksum_pkg::*;
#(
   parameter int unsigned W     = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_last,
   input  logic             in_odd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_csum,
   output logic [CNT_W-1:0] out_beats
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state;
   logic [W-1:0]     acc;
   logic [W-1:0]     acc_x;
   logic [CNT_W-1:0] count;
   logic             mode;

   logic             beat;
   logic             take;
   logic             first;
   logic [W-1:0]     acc_nx;
   logic [CNT_W-1:0] cnt_nx;
   logic             mode_nx;

   // Result register frees up in the same cycle the consumer takes it.
   assign in_ready = !out_valid || out_ready;

   for (genvar i = 0; i < int'(W); i++) begin : g_xor
      mux_xor_bit u_xor (
         .a   (acc[i]),
         .b   (in_data[i]),
         .y_c (acc_x[i])
      );
   end

   // Any beat outside ACCUM (IDLE, or DONE while the result drains) opens a packet.
   always_comb begin
      beat    = in_valid && in_ready;
      take    = out_valid && out_ready;
      first   = (state != ACCUM);
      acc_nx  = acc_x;
      cnt_nx  = (count == CNT_MAX) ? count : count + CNT_W'(1);
      mode_nx = mode;
      if (first) begin
         acc_nx  = in_data;
         cnt_nx  = CNT_W'(1);
         mode_nx = in_odd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         count     <= '0;
         mode      <= 1'b0;
         out_valid <= 1'b0;
         out_csum  <= '0;
         out_beats <= '0;
      end else if (beat) begin
         acc   <= acc_nx;
         count <= cnt_nx;
         mode  <= mode_nx;
         if (in_last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_csum  <= mode_nx ? ~acc_nx : acc_nx;
            out_beats <= cnt_nx;
         end else begin
            state     <= ACCUM;
            out_valid <= 1'b0;
         end
      end else if (take) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         acc       <= '0;
         count     <= '0;
      end
   end

endmodule

// File: tb/tb_stream_xor_checksum.sv
// Scoreboard bench for stream_xor_checksum, with a second instance at CNT_W=2
// sharing the same stimulus to exercise counter saturation.
module tb_stream_xor_checksum;

   typedef struct {
      logic [7:0] csum;
      int         beats;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready, in_ready2;
   logic [7:0] in_data;
   logic       in_last;
   logic       in_odd;
   logic       out_valid, out_valid2;
   logic       out_ready;
   logic [7:0] out_csum, out_csum2;
   logic [7:0] out_beats;
   logic [1:0] out_beats2;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];
   exp_t mon_e;
   bit   rand_rdy = 1'b0;

   logic [7:0] m_acc;
   int         m_cnt;
   logic       m_mode;
   bit         m_first = 1'b1;

   always #5 clk = ~clk;

   stream_xor_checksum #(.W(8), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .in_odd(in_odd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_csum(out_csum), .out_beats(out_beats)
   );

   stream_xor_checksum #(.W(8), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_data(in_data), .in_last(in_last), .in_odd(in_odd),
      .out_valid(out_valid2), .out_ready(out_ready),
      .out_csum(out_csum2), .out_beats(out_beats2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Drive one beat from posedge+1, wait for acceptance, update the model.
   task automatic send(input logic [7:0] d, input logic last, input logic odd);
      int budget = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      in_odd   = odd;
      @(negedge clk);
      while (!in_ready && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 32'(in_ready), 32'd1);
      end else begin
         if (m_first) begin
            m_acc  = d;
            m_cnt  = 1;
            m_mode = odd;
         end else begin
            m_acc = m_acc ^ d;
            m_cnt++;
         end
         if (last) begin
            sb.push_back('{csum: (m_mode ? ~m_acc : m_acc), beats: m_cnt});
            m_first = 1'b1;
         end else begin
            m_first = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'($urandom);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Result monitor: every take is compared against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         check("result_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("csum", 32'(out_csum), 32'(mon_e.csum));
            check("beats", 32'(out_beats), 32'(min_int(mon_e.beats, 255)));
            check("valid_sat", 32'(out_valid2), 32'd1);
            check("csum_sat", 32'(out_csum2), 32'(mon_e.csum));
            check("beats_sat", 32'(out_beats2), 32'(min_int(mon_e.beats, 3)));
         end
      end
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired @%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      int budget;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      in_odd    = 1'b0;
      out_ready = 1'b1;
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_csum", 32'(out_csum), 32'd0);
      check("rst_out_beats", 32'(out_beats), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      // Three-beat packet, even parity.
      send(8'h0F, 1'b0, 1'b0);
      send(8'hF0, 1'b0, 1'b1);
      send(8'hAA, 1'b1, 1'b1);
      check("latency_valid", 32'(out_valid), 32'd1);
      idle(2);

      // Single zero beat, odd parity, valid for exactly one cycle.
      send(8'h00, 1'b1, 1'b1);
      check("single_valid", 32'(out_valid), 32'd1);
      idle(1);
      check("single_dropped", 32'(out_valid), 32'd0);

      // Backpressure holds the result and blocks input.
      out_ready = 1'b0;
      send(8'h3C, 1'b1, 1'b0);
      idle(0);
      for (int i = 0; i < 4; i++) begin
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_in_ready_sat", 32'(in_ready2), 32'd0);
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_csum", 32'(out_csum), 32'h3C);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      idle(1);

      // Back-to-back single-beat packets.
      send(8'h11, 1'b1, 1'b0);
      check("b2b_valid0", 32'(out_valid), 32'd1);
      send(8'h22, 1'b1, 1'b0);
      check("b2b_valid1", 32'(out_valid), 32'd1);
      check("b2b_csum1", 32'(out_csum), 32'h22);
      idle(2);

      // Five beats: narrow counter saturates at 3.
      for (int i = 0; i < 5; i++) send(8'h01, 1'(i == 4), 1'b0);
      idle(2);

      // Reset mid-packet discards the partial accumulation.
      send(8'h12, 1'b0, 1'b0);
      send(8'h34, 1'b0, 1'b0);
      idle(0);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      m_first = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(8'h56, 1'b1, 1'b0);
      idle(2);

      // Reset while a result is held drops it immediately.
      out_ready = 1'b0;
      send(8'h77, 1'b1, 1'b0);
      idle(0);
      check("hold_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_hold_valid", 32'(out_valid), 32'd0);
      check("rst_hold_csum", 32'(out_csum), 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      idle(1);

      // Random packets under random backpressure.
      rand_rdy = 1'b1;
      for (int p = 0; p < 16; p++) begin
         len = $urandom_range(1, 6);
         for (int b = 0; b < len; b++)
            send(8'($urandom), 1'(b == len - 1), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) idle(1);
      end
      idle(0);
      rand_rdy = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      budget = 0;
      while (sb.size() != 0 && budget < 50) begin
         @(posedge clk);
         #1;
         budget++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
